nios2_ci_core_onchip_loader: RTL and testbench

Stream-to-memory loader sitting directly upstream of the 8192×32 on-chip RAM's second Avalon-MM slave port. It accepts 32-bit words on an Avalon-ST sink and writes them to consecutive RAM word addresses from a programmable base. It can optionally read the region back and check an additive checksum. Nios II controls it through a small CSR slave and can take an interrupt on completion.

---
 rtl/nios2_ci_core_onchip_loader_pkg.sv | 30 +++
 rtl/nios2_ci_core_onchip_loader_csr.sv | 101 ++++++++++
 rtl/nios2_ci_core_onchip_loader.sv | 178 +++++++++++++++++
 tb/tb_nios2_ci_core_onchip_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_ci_core_onchip_loader_pkg.sv
// Shared definitions for the on-chip RAM stream loader: CSR offsets, control and
// status bit positions, and the loader state encoding.
package nios2_ci_core_onchip_loader_pkg;

  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_STATUS = 3'd1;
  localparam logic [2:0] CSR_BASE   = 3'd2;
  localparam logic [2:0] CSR_LEN    = 3'd3;
  localparam logic [2:0] CSR_COUNT  = 3'd4;
  localparam logic [2:0] CSR_WSUM   = 3'd5;
  localparam logic [2:0] CSR_RSUM   = 3'd6;

  localparam int CTRL_GO        = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_VERIFY_EN = 2;
  localparam int CTRL_IRQ_EN    = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;
  localparam int ST_VFAIL   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    VDRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/nios2_ci_core_onchip_loader_csr.sv
// CSR slave for the loader: configuration registers, sticky status bits with
// write-1-to-clear, registered readback mux and the level interrupt.
module nios2_ci_core_onchip_loader_csr
  import nios2_ci_core_onchip_loader_pkg::*;
#(
  parameter int MEM_AW    = 13,
  parameter int MEM_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  input  logic              busy,
  input  logic              clr_status,
  input  logic              set_done,
  input  logic              set_aborted,
  input  logic              set_vfail,
  input  logic [31:0]       count,
  input  logic [31:0]       wsum,
  input  logic [31:0]       rsum,
  output logic              go,
  output logic              abort,
  output logic              verify_en,
  output logic [MEM_AW-1:0] base,
  output logic [MEM_AW:0]   len
);

  localparam int LW = MEM_AW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(MEM_WORDS);

  logic          wr_ctrl;
  logic          wr_status;
  logic          wr_base;
  logic          wr_len;
  logic          irq_en;
  logic          done;
  logic          aborted;
  logic          vfail;
  logic [LW-1:0] len_in;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign wr_ctrl   = csr_write && (csr_address == CSR_CTRL);
  assign wr_status = csr_write && (csr_address == CSR_STATUS);
  assign wr_base   = csr_write && (csr_address == CSR_BASE) && !busy;
  assign wr_len    = csr_write && (csr_address == CSR_LEN) && !busy;
  assign len_in    = csr_writedata[LW-1:0];

  assign go    = wr_ctrl && csr_writedata[CTRL_GO];
  assign abort = wr_ctrl && csr_writedata[CTRL_ABORT];
  assign irq   = irq_en && (done || aborted);

  assign unused_wdata = ^csr_writedata[31:LW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      verify_en <= 1'b0;
      irq_en    <= 1'b0;
      base      <= '0;
      len       <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      vfail     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        verify_en <= csr_writedata[CTRL_VERIFY_EN];
        irq_en    <= csr_writedata[CTRL_IRQ_EN];
      end
      if (wr_base) base <= csr_writedata[MEM_AW-1:0];
      if (wr_len)  len  <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
      // Hardware set has priority over both the GO clear and a W1C in the same cycle.
      done    <= (done    && !(wr_status && csr_writedata[ST_DONE])    && !clr_status) || set_done;
      aborted <= (aborted && !(wr_status && csr_writedata[ST_ABORTED]) && !clr_status) || set_aborted;
      vfail   <= (vfail   && !(wr_status && csr_writedata[ST_VFAIL])   && !clr_status) || set_vfail;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_CTRL:   rd_mux = {28'd0, irq_en, verify_en, 2'b00};
      CSR_STATUS: rd_mux = {28'd0, vfail, aborted, done, busy};
      CSR_BASE:   rd_mux = {{(32-MEM_AW){1'b0}}, base};
      CSR_LEN:    rd_mux = {{(32-LW){1'b0}}, len};
      CSR_COUNT:  rd_mux = count;
      CSR_WSUM:   rd_mux = wsum;
      CSR_RSUM:   rd_mux = rsum;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csr_readdata <= '0;
    else if (csr_read) csr_readdata <= rd_mux;
  end

endmodule

// File: rtl/nios2_ci_core_onchip_loader.sv
// Avalon-ST to on-chip RAM loader: writes a stream to BASE..BASE+LEN-1 (wrapping)
// and optionally reads the region back to compare additive checksums.
//
// Stream handshake: a word moves when snk_valid && snk_ready at a rising clk edge;
// snk_ready is high only in WRITE and does not depend on snk_valid.
module nios2_ci_core_onchip_loader
  import nios2_ci_core_onchip_loader_pkg::*;
#(
  parameter int MEM_AW    = 13,
  parameter int MEM_WORDS = 8192
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [1:0]        dbg_state
);

  localparam int LW = MEM_AW + 1;

  state_t          state;
  state_t          state_n;
  logic [LW-1:0]   offset;
  logic [LW-1:0]   len;
  logic [MEM_AW-1:0] base;
  logic [MEM_AW-1:0] addr;
  logic [31:0]     count;
  logic [31:0]     wsum;
  logic [31:0]     rsum;
  logic [31:0]     rsum_final;
  logic            rd_valid;
  logic            go;
  logic            abort;
  logic            verify_en;
  logic            go_fire;
  logic            xfer;
  logic            last_pos;
  logic            set_done;
  logic            set_aborted;
  logic            set_vfail;

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign dbg_state      = state;
  assign addr           = base + offset[MEM_AW-1:0];
  assign last_pos       = (offset == len - LW'(1));
  assign rsum_final     = rsum + mem_readdata;

  nios2_ci_core_onchip_loader_csr #(
    .MEM_AW    (MEM_AW),
    .MEM_WORDS (MEM_WORDS)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .irq           (irq),
    .busy          (state != IDLE),
    .clr_status    (go_fire),
    .set_done      (set_done),
    .set_aborted   (set_aborted),
    .set_vfail     (set_vfail),
    .count         (count),
    .wsum          (wsum),
    .rsum          (rsum),
    .go            (go),
    .abort         (abort),
    .verify_en     (verify_en),
    .base          (base),
    .len           (len)
  );

  always_comb begin
    state_n        = state;
    snk_ready      = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    go_fire        = 1'b0;
    xfer           = 1'b0;
    set_done       = 1'b0;
    set_aborted    = 1'b0;
    set_vfail      = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          go_fire = 1'b1;
          if (len == '0) set_done = 1'b1;
          else state_n = WRITE;
        end
      end
      WRITE: begin
        snk_ready      = 1'b1;
        mem_chipselect = snk_valid;
        mem_write      = snk_valid;
        mem_address    = addr;
        mem_writedata  = snk_data;
        xfer           = snk_valid;
        // The word accepted in an abort cycle still lands in RAM and is counted.
        if (abort) begin
          state_n     = IDLE;
          set_aborted = 1'b1;
        end else if (xfer && last_pos) begin
          if (verify_en) state_n = VERIFY;
          else begin
            state_n  = IDLE;
            set_done = 1'b1;
          end
        end
      end
      VERIFY: begin
        mem_chipselect = 1'b1;
        mem_address    = addr;
        if (abort) begin
          state_n     = IDLE;
          set_aborted = 1'b1;
        end else if (last_pos) state_n = VDRAIN;
      end
      VDRAIN: begin
        state_n = IDLE;
        if (abort) set_aborted = 1'b1;
        else begin
          set_done  = 1'b1;
          set_vfail = (rsum_final != wsum);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      offset   <= '0;
      count    <= '0;
      wsum     <= '0;
      rsum     <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      rd_valid <= (state == VERIFY);
      if (go_fire) begin
        offset <= '0;
        count  <= '0;
        wsum   <= '0;
        rsum   <= '0;
      end else begin
        if (xfer) begin
          count  <= count + 32'd1;
          wsum   <= wsum + snk_data;
          offset <= last_pos ? '0 : offset + LW'(1);
        end
        if (state == VERIFY) offset <= offset + LW'(1);
        // RAM q lags the read address by one cycle, so accumulate on the following cycle.
        if (rd_valid && (state == VERIFY || state == VDRAIN)) rsum <= rsum_final;
      end
    end
  end

endmodule

// File: tb/tb_nios2_ci_core_onchip_loader.sv
// Directed bench for the stream loader with a RAM model on the memory side.
module tb_nios2_ci_core_onchip_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic        irq;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [12:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata = '0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [8192];
  logic [12:0] wr_addr_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] tx_words [8];
  int          bad_wr = 0;
  bit          corrupt = 1'b0;

  always #5 clk = ~clk;

  nios2_ci_core_onchip_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .irq            (irq),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .dbg_state      (dbg_state)
  );

  // RAM model with one-cycle read latency; optional +1 corruption on address 0.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      wr_addr_q.push_back(mem_address);
      exp_q.push_back(mem_writedata);
      ram[mem_address] <= mem_writedata;
      if (!snk_valid) bad_wr++;
    end
    if (mem_chipselect && !mem_write)
      mem_readdata <= ram[mem_address] + ((corrupt && mem_address == 13'd0) ? 32'd1 : 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0; csr_writedata = '0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    d = csr_readdata; csr_read = 1'b0;
  endtask

  task automatic send_words(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 100) begin
      @(negedge clk);
      snk_valid = 1'b1; snk_data = tx_words[i];
      if (snk_ready) i++;
      guard++;
    end
    @(negedge clk);
    snk_valid = 1'b0; snk_data = '0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL send_words: accepted %0d words, required %0d", i, n);
    end
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    int tries = 0;
    d = 32'h1;
    while (d[0] && tries < 40) begin
      csr_rd(3'd1, d);
      tries++;
    end
    checks++;
    if (d[0]) begin
      failures++;
      $display("FAIL wait_idle: BUSY still set after %0d polls", tries);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({snk_ready, mem_chipselect, mem_write, irq} !== 4'b0000 || mem_address !== 13'd0 ||
        mem_writedata !== 32'd0 || csr_readdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b cs=%b wr=%b irq=%b addr=%h wd=%h rd=%h, required all 0",
               snk_ready, mem_chipselect, mem_write, irq, mem_address, mem_writedata, csr_readdata);
    end
    checks++;
    if (mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
      failures++;
      $display("FAIL reset_consts: got be=%h clken=%b, required F/1", mem_byteenable, mem_clken);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    csr_rd(3'd1, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_status: got %h required 0", d); end
    csr_rd(3'd7, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reg7_zero: got %h required 0", d); end
  endtask

  task automatic test_basic_write();
    logic [31:0] d;
    wr_addr_q.delete(); exp_q.delete();
    csr_wr(3'd2, 32'h10);
    csr_wr(3'd3, 32'd4);
    csr_wr(3'd0, 32'h1);
    checks++;
    if (snk_ready !== 1'b1) begin failures++; $display("FAIL go_ready: got %b required 1", snk_ready); end
    tx_words[0] = 1; tx_words[1] = 2; tx_words[2] = 3; tx_words[3] = 4;
    send_words(4);
    checks++;
    if (wr_addr_q.size() != 4) begin
      failures++;
      $display("FAIL basic_nwrites: got %0d required 4", wr_addr_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_addr_q[k] !== 13'(32'h10 + k) || exp_q[k] !== 32'(k + 1)) begin
          failures++;
          $display("FAIL basic_write%0d: got addr=%h data=%h required addr=%h data=%h",
                   k, wr_addr_q[k], exp_q[k], 13'(32'h10 + k), k + 1);
        end
      end
    end
    checks++;
    if (snk_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_low: got %b required 0", snk_ready); end
    csr_rd(3'd4, d);
    checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL basic_count: got %0d required 4", d); end
    csr_rd(3'd5, d);
    checks++;
    if (d !== 32'd10) begin failures++; $display("FAIL basic_wsum: got %0d required 10", d); end
    csr_rd(3'd1, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL basic_status: got %h required 2", d); end
  endtask

  task automatic test_verify(input bit bad);
    logic [31:0] d;
    logic [12:0] exp_addr [4];
    exp_addr[0] = 13'h1FFE; exp_addr[1] = 13'h1FFF; exp_addr[2] = 13'h0000; exp_addr[3] = 13'h0001;
    wr_addr_q.delete(); exp_q.delete();
    corrupt = bad;
    csr_wr(3'd2, 32'h1FFE);
    csr_wr(3'd3, 32'd4);
    csr_wr(3'd0, 32'h5);
    tx_words[0] = 32'h11111111; tx_words[1] = 32'h22222222;
    tx_words[2] = 32'h33333333; tx_words[3] = 32'h44444444;
    send_words(4);
    wait_idle();
    corrupt = 1'b0;
    checks++;
    if (wr_addr_q.size() != 4) begin
      failures++;
      $display("FAIL verify_nwrites: got %0d required 4", wr_addr_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_addr_q[k] !== exp_addr[k]) begin
          failures++;
          $display("FAIL verify_addr%0d: got %h required %h", k, wr_addr_q[k], exp_addr[k]);
        end
      end
    end
    csr_rd(3'd5, d);
    checks++;
    if (d !== 32'hAAAAAAAA) begin failures++; $display("FAIL verify_wsum: got %h required AAAAAAAA", d); end
    csr_rd(3'd6, d);
    checks++;
    if (d !== (bad ? 32'hAAAAAAAB : 32'hAAAAAAAA)) begin
      failures++;
      $display("FAIL verify_rsum: got %h required %h", d, bad ? 32'hAAAAAAAB : 32'hAAAAAAAA);
    end
    csr_rd(3'd1, d);
    checks++;
    if (d !== (bad ? 32'hA : 32'h2)) begin
      failures++;
      $display("FAIL verify_status: got %h required %h", d, bad ? 32'hA : 32'h2);
    end
  endtask

  task automatic test_valid_toggle();
    logic [31:0] d;
    logic [4:0] pat;
    int j = 0;
    pat = 5'b10101;
    wr_addr_q.delete(); exp_q.delete();
    bad_wr = 0;
    csr_wr(3'd2, 32'h100);
    csr_wr(3'd3, 32'd3);
    csr_wr(3'd0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      snk_valid = pat[4-k];
      snk_data = pat[4-k] ? 32'(5 + j) : 32'hDEAD0000 + 32'(k);
      if (pat[4-k]) j++;
    end
    @(negedge clk);
    snk_valid = 1'b0; snk_data = '0;
    checks++;
    if (wr_addr_q.size() != 3 || bad_wr != 0) begin
      failures++;
      $display("FAIL toggle_nwrites: got %0d writes (%0d with valid low), required 3 (0)",
               wr_addr_q.size(), bad_wr);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wr_addr_q[k] !== 13'(32'h100 + k) || exp_q[k] !== 32'(5 + k)) begin
          failures++;
          $display("FAIL toggle_write%0d: got addr=%h data=%h required addr=%h data=%h",
                   k, wr_addr_q[k], exp_q[k], 13'(32'h100 + k), 5 + k);
        end
      end
    end
    csr_rd(3'd1, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL toggle_status: got %h required 2", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    csr_wr(3'd2, 32'h200);
    csr_wr(3'd3, 32'd8);
    csr_wr(3'd0, 32'h1);
    csr_wr(3'd2, 32'h55);
    csr_rd(3'd2, d);
    checks++;
    if (d !== 32'h200) begin failures++; $display("FAIL base_busy_ignored: got %h required 200", d); end
    tx_words[0] = 1; tx_words[1] = 2;
    send_words(2);
    @(negedge clk);
    csr_address = 3'd0; csr_writedata = 32'h2; csr_write = 1'b1;
    snk_valid = 1'b1; snk_data = 32'd3;
    @(negedge clk);
    csr_write = 1'b0; csr_writedata = '0; snk_valid = 1'b0; snk_data = '0;
    checks++;
    if (snk_ready !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL abort_idle: got ready=%b state=%0d required 0/0", snk_ready, dbg_state);
    end
    csr_rd(3'd4, d);
    checks++;
    if (d !== 32'd3) begin failures++; $display("FAIL abort_count: got %0d required 3", d); end
    csr_rd(3'd5, d);
    checks++;
    if (d !== 32'd6) begin failures++; $display("FAIL abort_wsum: got %0d required 6", d); end
    csr_rd(3'd1, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL abort_status: got %h required 4", d); end
  endtask

  task automatic test_len_zero_irq();
    logic [31:0] d;
    wr_addr_q.delete(); exp_q.delete();
    csr_wr(3'd3, 32'd0);
    csr_wr(3'd0, 32'h9);
    checks++;
    if (irq !== 1'b1 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL len0_irq: got irq=%b state=%0d required 1/0", irq, dbg_state);
    end
    csr_rd(3'd1, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL len0_status: got %h required 2", d); end
    csr_wr(3'd1, 32'h2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL len0_irq_clear: got %b required 0", irq); end
    csr_rd(3'd1, d);
    checks++;
    if (d !== 32'h0 || wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL len0_cleared: got status=%h writes=%0d required 0/0", d, wr_addr_q.size());
    end
  endtask

  task automatic test_len_clamp();
    logic [31:0] d;
    csr_wr(3'd3, 32'h3FFF);
    csr_rd(3'd3, d);
    checks++;
    if (d !== 32'd8192) begin failures++; $display("FAIL len_clamp: got %0d required 8192", d); end
    csr_wr(3'd3, 32'd8191);
    csr_rd(3'd3, d);
    checks++;
    if (d !== 32'd8191) begin failures++; $display("FAIL len_noclamp: got %0d required 8191", d); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_verify(1'b0);
    test_verify(1'b1);
    test_valid_toggle();
    test_abort();
    test_len_zero_irq();
    test_len_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
